div_unit: RTL and testbench

Multicycle signed 32-bit divider answering the control unit's DIV request. It captures rs and rt from the A/B registers when `DivCtrl` is pulsed, runs a restoring shift-subtract division, then writes the quotient and remainder into its HI/LO output registers. It reports completion with `DivStop` and divide-by-zero with `DivZero`, both of which the control unit consumes. It sits beside the multiplier, feeding the HI/LO source muxes.

---
 rtl/div_unit.sv | 135 +++++++++++++
 tb/tb_div_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
//------------------------------------------------------------------------------
// Module      : div_unit
// Description : Multicycle signed restoring divider producing MIPS-style HI/LO.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivStop,
    output logic             DivZero,
    output logic             DivBusy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic             sq_q;
    logic             sr_q;
    logic             ctrl_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             stop_q;
    logic             zero_q;
    logic             busy_q;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic             start;

    // Magnitudes are plain unsigned negations, so the most negative value maps to itself.
    assign abs_a = A[WIDTH-1] ? (-A) : A;
    assign abs_b = B[WIDTH-1] ? (-B) : B;

    // A clear borrow bit in the 33-bit difference means the shifted remainder >= divisor.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    assign rem_ge    = ~rem_diff[WIDTH];
    assign rem_d     = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_d     = {quo_q[WIDTH-2:0], rem_ge};

    // Only a rising DivCtrl starts work, so a held request yields a single operation.
    assign start = DivCtrl & ~ctrl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            ctrl_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            stop_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ctrl_q <= DivCtrl;
            stop_q <= 1'b0;
            zero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (B == '0) begin
                            zero_q <= 1'b1;
                        end else begin
                            quo_q   <= abs_a;
                            dvs_q   <= abs_b;
                            rem_q   <= '0;
                            sq_q    <= A[WIDTH-1] ^ B[WIDTH-1];
                            sr_q    <= A[WIDTH-1];
                            cnt_q   <= CW'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        lo_q    <= sq_q ? (-quo_d) : quo_d;
                        hi_q    <= sr_q ? (-rem_d) : rem_d;
                        stop_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign HI      = hi_q;
    assign LO      = lo_q;
    assign DivStop = stop_q;
    assign DivZero = zero_q;
    assign DivBusy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_div_unit
// Description : Directed self-checking bench for div_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        DivCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        DivStop;
    logic        DivZero;
    logic        DivBusy;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .DivCtrl (DivCtrl),
        .A       (A),
        .B       (B),
        .HI      (HI),
        .LO      (LO),
        .DivStop (DivStop),
        .DivZero (DivZero),
        .DivBusy (DivBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse, operands scrambled after the start edge, then full timing check.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi);
        int cyc;
        int busy_cnt;
        int zero_seen;
        @(negedge clk);
        A = a;
        B = b;
        DivCtrl = 1'b1;
        @(negedge clk);
        DivCtrl = 1'b0;
        A = $urandom;
        B = $urandom;
        cyc = 0;
        busy_cnt = 0;
        zero_seen = 0;
        while (!DivStop && cyc < 40) begin
            if (DivBusy) busy_cnt++;
            if (DivZero) zero_seen = 1;
            @(negedge clk);
            cyc++;
        end
        if (DivBusy) busy_cnt++;
        check({tag, " latency"}, 32'(cyc), 32'd32);
        check({tag, " LO"}, LO, elo);
        check({tag, " HI"}, HI, ehi);
        check({tag, " zero"}, 32'(zero_seen), 32'd0);
        @(negedge clk);
        check({tag, " stop_drop"}, {31'd0, DivStop}, 32'd0);
        check({tag, " busy_drop"}, {31'd0, DivBusy}, 32'd0);
        check({tag, " busy_len"}, 32'(busy_cnt), 32'd33);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stops;
        logic [31:0] lo_s;
        logic [31:0] hi_s;
        reset = 1'b1;
        DivCtrl = 1'b0;
        A = 32'd0;
        B = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst HI", HI, 32'd0);
        check("rst LO", LO, 32'd0);
        check("rst flags", {29'd0, DivStop, DivZero, DivBusy}, 32'd0);

        do_div("7/2", 32'd7, 32'd2, 32'd3, 32'd1);
        do_div("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);

        // Divide by zero: one-cycle flag, HI/LO untouched, no done pulse.
        @(negedge clk);
        A = 32'd5;
        B = 32'd0;
        DivCtrl = 1'b1;
        @(negedge clk);
        DivCtrl = 1'b0;
        check("dz pulse", {31'd0, DivZero}, 32'd1);
        check("dz busy", {31'd0, DivBusy}, 32'd0);
        @(negedge clk);
        check("dz drop", {31'd0, DivZero}, 32'd0);
        check("dz HI", HI, 32'd1);
        check("dz LO", LO, 32'hFFFF_FFFD);
        stops = 0;
        repeat (36) begin
            @(negedge clk);
            if (DivStop) stops++;
        end
        check("dz nostop", 32'(stops), 32'd0);

        do_div("5/3", 32'd5, 32'd3, 32'd1, 32'd2);
        do_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        do_div("0/-9", 32'd0, 32'hFFFF_FFF7, 32'd0, 32'd0);
        do_div("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);

        // Reset after the tenth iteration aborts the operation.
        @(negedge clk);
        A = 32'd100;
        B = 32'd7;
        DivCtrl = 1'b1;
        @(negedge clk);
        DivCtrl = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        check("abort flags", {29'd0, DivStop, DivZero, DivBusy}, 32'd0);
        stops = 0;
        repeat (36) begin
            @(negedge clk);
            if (DivStop) stops++;
        end
        check("abort nostop", 32'(stops), 32'd0);
        do_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2);

        // Held DivCtrl: exactly one operation until the request drops.
        @(negedge clk);
        A = 32'd9;
        B = 32'd4;
        DivCtrl = 1'b1;
        stops = 0;
        lo_s = 32'd0;
        hi_s = 32'd0;
        repeat (40) begin
            @(negedge clk);
            if (DivStop) begin
                stops++;
                lo_s = LO;
                hi_s = HI;
            end
        end
        check("held stops", 32'(stops), 32'd1);
        check("held LO", lo_s, 32'd2);
        check("held HI", hi_s, 32'd1);
        DivCtrl = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (DivStop) stops++;
        end
        check("held drop stops", 32'(stops), 32'd1);
        do_div("9/4 rearm", 32'd9, 32'd4, 32'd2, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
